// File: rtl/rr_arb_mux.sv
// ---------------------------------------------------------------------------
// rr_arb_mux
//
// Merges N valid/ready producer streams onto one consumer stream through a
// single registered output stage. Each accepted beat is tagged with the index
// of the channel it came from. Arbitration is round-robin by default or fixed
// priority (lowest index wins) when FIXED_PRIO is set.
//
// Parameters:
//   WIDTH      data width of every channel
//   N          number of input channels (2..16)
//   FIXED_PRIO 0 = round-robin, 1 = fixed priority, lowest index wins
//   SELW       width of the channel index (derived, leave at default)
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   reset      asynchronous active-high reset
//   in_valid   bit i: channel i presents a beat
//   in_data    channel i data in bits [i*WIDTH +: WIDTH]
//   in_ready   bit i: channel i beat accepted this cycle (with in_valid[i])
//   out_valid  output register holds a beat
//   out_data   buffered beat data
//   out_sel    source channel of the buffered beat
//   out_ready  consumer accepts the buffered beat
// ---------------------------------------------------------------------------
module rr_arb_mux #(
   parameter int WIDTH      = 32,
   parameter int N          = 4,
   parameter int FIXED_PRIO = 0,
   parameter int SELW       = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         in_valid,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   input  logic                 out_ready
);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  gnt_idx;
   logic             gnt_any;
   logic [N-1:0]     grant;
   logic [SELW:0]    scan;
   logic             load;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;
   logic [SELW-1:0]  ptr_next;

   // Grant search. In round-robin mode the scan starts at ptr and wraps
   // modulo N (one extra bit in scan holds the unwrapped sum), so the first
   // valid channel at or after ptr wins. In fixed-priority mode the scan
   // simply starts at 0. The first hit latches and later hits are ignored.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      scan    = '0;
      for (int k = 0; k < N; k++) begin
         if (FIXED_PRIO != 0) begin
            scan = (SELW+1)'(k);
         end else begin
            scan = {1'b0, ptr} + (SELW+1)'(k);
            if (scan >= (SELW+1)'(N)) begin
               scan = scan - (SELW+1)'(N);
            end
         end
         if (!gnt_any && in_valid[scan[SELW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan[SELW-1:0];
         end
      end
   end

   // One-hot grant vector derived from the winning index.
   always_comb begin
      grant = '0;
      if (gnt_any) begin
         grant[gnt_idx] = 1'b1;
      end
   end

   // The output register has room when it is empty or being drained this
   // cycle. in_ready is held low during reset so no producer believes a beat
   // was taken while the register is being cleared.
   always_comb begin
      load = !out_valid || out_ready;
      xfer = gnt_any && load;
      if (load && !reset) begin
         in_ready = grant;
      end else begin
         in_ready = '0;
      end
   end

   // Data select for the winning channel, written as a compare-per-channel
   // mux so the index never feeds a variable part-select.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == SELW'(i)) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next pointer is the channel after the winner, wrapping N-1 to 0 so a
   // non-power-of-two N never produces an out-of-range pointer.
   always_comb begin
      if (gnt_idx == SELW'(N-1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = gnt_idx + SELW'(1);
      end
   end

   // Priority pointer: moves only on an input transfer and only in
   // round-robin mode; fixed priority leaves it at 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (xfer && (FIXED_PRIO == 0)) begin
         ptr <= ptr_next;
      end
   end

   // Output register. A new beat is loaded whenever a transfer happens, which
   // also covers the simultaneous drain-and-refill case at full rate. A drain
   // with no refill only clears out_valid; data and tag keep their values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_sel   <= gnt_idx;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_mux
//
// Directed testbench for rr_arb_mux. One instance runs round-robin with N=4,
// a second runs fixed priority with N=3. Inputs are driven between clock
// edges; registered outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_rr_arb_mux;

   logic         clk;
   logic         reset;

   logic [3:0]   in_valid;
   logic [127:0] in_data;
   logic [3:0]   in_ready;
   logic         out_valid;
   logic [31:0]  out_data;
   logic [1:0]   out_sel;
   logic         out_ready;

   logic [2:0]   fp_in_valid;
   logic [95:0]  fp_in_data;
   logic [2:0]   fp_in_ready;
   logic         fp_out_valid;
   logic [31:0]  fp_out_data;
   logic [1:0]   fp_out_sel;
   logic         fp_out_ready;

   int vectors;
   int miscompares;

   rr_arb_mux #(.WIDTH(32), .N(4), .FIXED_PRIO(0)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   rr_arb_mux #(.WIDTH(32), .N(3), .FIXED_PRIO(1)) dut_fp (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (fp_in_valid),
      .in_data   (fp_in_data),
      .in_ready  (fp_in_ready),
      .out_valid (fp_out_valid),
      .out_data  (fp_out_data),
      .out_sel   (fp_out_sel),
      .out_ready (fp_out_ready)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives the round-robin instance's inputs.
   task automatic applyStimulus(input logic [3:0] v,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic rdy);
      in_valid  = v;
      in_data   = {d3, d2, d1, d0};
      out_ready = rdy;
   endtask

   // Single comparison point: counts the vector and reports a miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence covering reset, saturation, drain, backpressure,
   // skip/wrap, mid-stream reset and fixed priority.
   initial begin
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b1;
      fp_in_valid  = '0;
      fp_in_data   = '0;
      fp_out_ready = 1'b1;
      applyStimulus(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

      #12;
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_out_data",  out_data,       32'h0);
      checkOutput("rst_out_sel",   32'(out_sel),   32'h0);
      checkOutput("rst_in_ready",  32'(in_ready),  32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Round-robin saturation
      applyStimulus(4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b1);
      #1;
      checkOutput("sat_first_ready", 32'(in_ready), 32'h1);
      checkOutput("sat_not_yet_valid", 32'(out_valid), 32'h0);
      for (int k = 0; k < 8; k++) begin
         nextCycle();
         checkOutput($sformatf("sat_valid_%0d", k), 32'(out_valid), 32'h1);
         checkOutput($sformatf("sat_sel_%0d", k), 32'(out_sel), 32'(k % 4));
         checkOutput($sformatf("sat_data_%0d", k), out_data, 32'(32'hA0 + (k % 4)));
         checkOutput($sformatf("sat_ready_%0d", k), 32'(in_ready),
                     32'(1 << ((k + 1) % 4)));
      end

      // Drain without refill
      applyStimulus(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      #1;
      checkOutput("drain_in_ready", 32'(in_ready), 32'h0);
      nextCycle();
      checkOutput("drain_valid", 32'(out_valid), 32'h0);
      checkOutput("drain_data_hold", out_data, 32'hA3);
      checkOutput("drain_sel_hold", 32'(out_sel), 32'h3);

      // Backpressure: buffer 0x55 from channel 2, stall 4 cycles
      applyStimulus(4'b0100, 32'h0, 32'h0, 32'h55, 32'h0, 1'b0);
      #1;
      checkOutput("bp_load_ready", 32'(in_ready), 32'h4);
      nextCycle();
      checkOutput("bp_loaded_valid", 32'(out_valid), 32'h1);
      applyStimulus(4'b0001, 32'h77, 32'h0, 32'h0, 32'h0, 1'b0);
      #1;
      checkOutput("bp_ready_0", 32'(in_ready), 32'h0);
      for (int k = 0; k < 4; k++) begin
         nextCycle();
         checkOutput($sformatf("bp_data_%0d", k), out_data, 32'h55);
         checkOutput($sformatf("bp_sel_%0d", k), 32'(out_sel), 32'h2);
         checkOutput($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'h1);
         checkOutput($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 32'(in_ready), 32'h1);
      nextCycle();
      checkOutput("bp_pass_valid", 32'(out_valid), 32'h1);
      checkOutput("bp_pass_data", out_data, 32'h77);
      checkOutput("bp_pass_sel", 32'(out_sel), 32'h0);

      // Move ptr to 3 by taking channel 2 (ptr is 1 here)
      applyStimulus(4'b0100, 32'h0, 32'h0, 32'h33, 32'h0, 1'b1);
      #1;
      checkOutput("ptr1_ready", 32'(in_ready), 32'h4);
      nextCycle();
      checkOutput("ptr3_sel", 32'(out_sel), 32'h2);
      checkOutput("ptr3_data", out_data, 32'h33);

      // Skip and wrap: only channels 1 and 3 valid with ptr=3
      applyStimulus(4'b1010, 32'h0, 32'h11, 32'h0, 32'h13, 1'b1);
      #1;
      checkOutput("wrap_ready_ch3", 32'(in_ready), 32'h8);
      nextCycle();
      checkOutput("wrap_sel3", 32'(out_sel), 32'h3);
      checkOutput("wrap_data3", out_data, 32'h13);
      checkOutput("wrap_ptr0_ready", 32'(in_ready), 32'h2);
      nextCycle();
      checkOutput("wrap_sel1", 32'(out_sel), 32'h1);
      checkOutput("wrap_data1", out_data, 32'h11);
      checkOutput("wrap_ptr2_ready", 32'(in_ready), 32'h8);

      // Reset asserted mid-stream with a buffered beat
      applyStimulus(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_valid", 32'(out_valid), 32'h0);
      checkOutput("mid_rst_data",  out_data,       32'h0);
      checkOutput("mid_rst_sel",   32'(out_sel),   32'h0);
      checkOutput("mid_rst_ready", 32'(in_ready),  32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         nextCycle();
         checkOutput($sformatf("idle_valid_%0d", k), 32'(out_valid), 32'h0);
      end
      applyStimulus(4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b1);
      #1;
      checkOutput("post_rst_prio0", 32'(in_ready), 32'h1);
      applyStimulus(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

      // Fixed priority, N=3: channels 0 and 2 continuously valid
      fp_in_valid  = 3'b101;
      fp_in_data   = {32'hC2, 32'hC1, 32'hC0};
      fp_out_ready = 1'b1;
      #1;
      checkOutput("fp_ready_first", 32'(fp_in_ready), 32'h1);
      for (int k = 0; k < 3; k++) begin
         nextCycle();
         checkOutput($sformatf("fp_sel_%0d", k), 32'(fp_out_sel), 32'h0);
         checkOutput($sformatf("fp_data_%0d", k), fp_out_data, 32'hC0);
         checkOutput($sformatf("fp_ready_%0d", k), 32'(fp_in_ready), 32'h1);
      end
      fp_in_valid = 3'b100;
      #1;
      checkOutput("fp_drop0_ready", 32'(fp_in_ready), 32'h4);
      nextCycle();
      checkOutput("fp_ch2_valid", 32'(fp_out_valid), 32'h1);
      checkOutput("fp_ch2_sel", 32'(fp_out_sel), 32'h2);
      checkOutput("fp_ch2_data", fp_out_data, 32'hC2);
      fp_in_valid = 3'b000;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel, valid/ready round-robin arbitrating multiplexer with a registered output stage. It merges N producer streams, such as memory requests from fetch, load/store and debug ports, onto one consumer stream. Each accepted beat is tagged with its source channel index. It generalises the team's combinational 4:1 select mux with a configurable input count, per-channel handshake, fairness and one cycle of buffering.

## Interface
- WIDTH, 32, data width of every channel.
- N, 4, number of input channels; legal range 2..16.
- FIXED_PRIO, 0, arbitration mode: 0 selects round-robin, 1 selects fixed priority with the lowest index winning.
- SELW, $clog2(N), width of the channel index (derived; do not override).

Ports:
- clk  in  1  the block's single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  N  bit i = channel i presents a beat.
- in_data  in  N*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
- in_ready  out  N  bit i = channel i beat accepted this cycle when in_valid[i] is also high.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  buffered beat data.
- out_sel  out  SELW  source channel of the buffered beat.
- out_ready  in  1  consumer accepts the beat.

## Operation
- State: output register {out_valid, out_data, out_sel} and priority pointer ptr (SELW bits).
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0. Outputs hold these values while reset is high, independent of clk.
- Grant (combinational):
  - Round-robin: the winner is the first i with in_valid[i] high, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
  - Fixed priority: the winner is the lowest i with in_valid[i] high.
  - No valid input means no grant.
- load = !out_valid || out_ready. This is the output-register space condition.
- in_ready[i] = load && grant[i]. At most one in_ready bit is high. in_ready never depends on in_valid[j] for j≠i except through grant.
- Per edge:
  - Input transfer (any in_valid&in_ready): out_data<=in_data[g], out_sel<=g, out_valid<=1. In round-robin mode, ptr<=(g==N-1)?0:g+1. In fixed-priority mode, ptr is unused and stays 0.
  - Output drain without input transfer (out_valid && out_ready): out_valid<=0; out_data and out_sel hold their values.
  - Otherwise all state holds.
- A simultaneous output drain and input transfer is a pass-through at full rate: out_valid stays 1 and the register takes the new beat.
- Producer rule: once in_valid[i] is high it stays high with stable in_data until in_ready[i]. The grant may still move to another channel before acceptance if a higher-priority channel asserts meanwhile; this is legal.
- Consumer rule: while out_valid && !out_ready, out_data and out_sel are stable and all in_ready are 0.
- ptr only changes on an input transfer. Wrap-around is N-1→0. For non-power-of-2 N, ptr never takes values ≥N.

## Timing
- Latency is 1 cycle from input acceptance to out_valid.
- Throughput is 1 beat/cycle with out_ready held high.
- Fairness: with all N channels continuously valid in round-robin mode, each channel is granted exactly once per N consecutive transfers.
- in_ready is combinational from in_valid, out_valid and out_ready. There is no combinational path from in_data to any output.
- Reset asserted mid-stream: the buffered beat is discarded (out_valid=0) and ptr returns to 0 immediately. After deassertion, channel 0 has first priority.

## Test plan
- Reset and idle: assert reset mid-transfer with out_valid=1 -> outputs drop asynchronously to out_valid=0, out_data=0, out_sel=0, in_ready=0. After release, all inputs are idle for 5 cycles -> out_valid stays 0.
- Round-robin saturation (N=4, WIDTH=32): all channels valid with data 0xA0+i and out_ready=1 -> out_sel sequence 0,1,2,3,0,1,2,3 on consecutive cycles, out_data matching, first out_valid 1 cycle after the first acceptance.
- Skip and wrap: ptr=3 with only channels 1 and 3 valid -> channel 3 is granted and ptr becomes 0. Next grant is channel 1 and ptr becomes 2.
- Backpressure: buffered beat 0x55 from channel 2, out_ready=0 for 4 cycles -> out_data=0x55 and out_sel=2 stable, in_ready=0. When out_ready rises together with channel 0 valid (0x77), the next cycle shows out_data=0x77, out_sel=0 and out_valid remaining 1.
- Drain without refill: out_valid=1, out_ready=1, no inputs valid -> next cycle out_valid=0.
- Fixed-priority mode (FIXED_PRIO=1, N=3): channels 0 and 2 continuously valid -> channel 0 always wins and in_ready[2] stays 0. Dropping channel 0 -> channel 2 is granted in that same cycle.
